// File: rtl/ct_add_arb_pkg.sv
// Ciphertext types shared by the adder datapath, plus the arbiter's requester
// index type and default counter width.
package ct_add_arb_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS    = 13;
  localparam logic [W_BITS-1:0] Q_MOD = 13'd7710;

  typedef logic [N_SLOTS_L-1:0][W_BITS-1:0] vec_t;

  typedef struct packed {
    vec_t A;
    vec_t B;
  } CT_t;

  typedef logic req_idx_t;

  localparam int N_REQ         = 2;
  localparam int CNT_W_DEFAULT = 16;

  // One extra bit keeps the carry so a single conditional subtract reduces the sum.
  function automatic logic [W_BITS-1:0] modAdd(input logic [W_BITS-1:0] a,
                                               input logic [W_BITS-1:0] b);
    logic [W_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q_MOD}) begin
      s = s - {1'b0, Q_MOD};
    end
    return s[W_BITS-1:0];
  endfunction

endpackage

// File: rtl/ct_ct_add.sv
// Combinational ciphertext adder: every slot of both components is summed
// modulo Q_MOD. Operands are required to already be below Q_MOD.
module ct_ct_add
  import ct_add_arb_pkg::*;
(
  input  CT_t i_a,
  input  CT_t i_b,
  output CT_t o_sum
);

  always_comb begin
    o_sum = '0;
    for (int s = 0; s < N_SLOTS_L; s++) begin
      o_sum.A[s] = modAdd(i_a.A[s], i_b.A[s]);
      o_sum.B[s] = modAdd(i_a.B[s], i_b.B[s]);
    end
  end

endmodule

// File: rtl/ct_add_arb.sv
// Two-requester front end for one shared ciphertext adder: arbitrates, adds,
// and holds the result in a one-entry output register with per-requester counters.
module ct_add_arb
  import ct_add_arb_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  CT_t  [1:0]                req_ct1,
  input  CT_t  [1:0]                req_ct2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output CT_t                       out_ct,
  output req_idx_t                  out_id,
  output logic [1:0][CNT_W-1:0]     done_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                r_state;
  CT_t                   r_outCt;
  req_idx_t              r_outId;
  req_idx_t              r_lastGrant;
  logic [1:0][CNT_W-1:0] r_doneCnt;

  logic [1:0] w_grant;
  req_idx_t   w_sel;
  logic       w_slotFree;
  logic       w_xfer;
  logic       w_drain;
  CT_t        w_op1;
  CT_t        w_op2;
  CT_t        w_sum;

  // Grant looks only at req_valid and the pointer, so out_ready cannot ripple into it.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11: begin
        if ((RR_EN != 0) && (r_lastGrant == 1'b0)) begin
          w_grant = 2'b10;
        end else begin
          w_grant = 2'b01;
        end
      end
      default: w_grant = 2'b00;
    endcase
  end

  assign w_sel      = w_grant[1];
  assign w_slotFree = (r_state == EMPTY) || out_ready;
  assign req_ready  = w_grant & {2{w_slotFree & rst_n}};
  assign w_xfer     = |(req_valid & req_ready);
  assign w_drain    = (r_state == FULL) && out_ready;

  assign w_op1 = req_ct1[w_sel];
  assign w_op2 = req_ct2[w_sel];

  ct_ct_add u_add (
    .i_a   (w_op1),
    .i_b   (w_op2),
    .o_sum (w_sum)
  );

  // Output register, pointer and counters; a reload on drain keeps FULL with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_outCt     <= '0;
      r_outId     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_doneCnt   <= '0;
    end else begin
      if (w_drain && (r_doneCnt[r_outId] != {CNT_W{1'b1}})) begin
        r_doneCnt[r_outId] <= r_doneCnt[r_outId] + CNT_W'(1);
      end
      if (w_xfer) begin
        r_outCt     <= w_sum;
        r_outId     <= w_sel;
        r_lastGrant <= w_sel;
      end
      case (r_state)
        EMPTY:   if (w_xfer) r_state <= FULL;
        FULL:    if (out_ready && !w_xfer) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_ct    = r_outCt;
  assign out_id    = r_outId;
  assign done_cnt  = r_doneCnt;

endmodule

// File: tb/tb_ct_add_arb.sv
// Self-checking bench: a round-robin/16-bit instance and a fixed-priority/2-bit
// instance share stimulus; a cycle model feeds per-instance scoreboards.
module tb_ct_add_arb;
  import ct_add_arb_pkg::*;

  localparam int CNT_W1 = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [1:0]              req_valid;
  CT_t  [1:0]              req_ct1;
  CT_t  [1:0]              req_ct2;
  logic                    out_ready;

  logic [1:0]              reqReady0, reqReady1;
  logic                    outValid0, outValid1;
  CT_t                     outCt0, outCt1;
  logic                    outId0, outId1;
  logic [1:0][15:0]        doneCnt0;
  logic [1:0][CNT_W1-1:0]  doneCnt1;

  always #5 clk = ~clk;

  ct_add_arb #(.RR_EN(1), .CNT_W(16)) dutRr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(reqReady0),
    .req_ct1(req_ct1), .req_ct2(req_ct2), .out_valid(outValid0),
    .out_ready(out_ready), .out_ct(outCt0), .out_id(outId0), .done_cnt(doneCnt0)
  );

  ct_add_arb #(.RR_EN(0), .CNT_W(CNT_W1)) dutFp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(reqReady1),
    .req_ct1(req_ct1), .req_ct2(req_ct2), .out_valid(outValid1),
    .out_ready(out_ready), .out_ct(outCt1), .out_id(outId1), .done_cnt(doneCnt1)
  );

  typedef struct {
    logic id;
    CT_t  ct;
  } exp_t;

  typedef struct {
    logic [12:0] a1, a2, b1, b2, expA, expB;
  } vec_rec_t;

  exp_t sbQ0[$];
  exp_t sbQ1[$];
  logic idLog0[$];
  logic idLog1[$];
  bit   fpReady1Seen;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed priority
  bit   mValid[2];
  logic mId[2];
  logic mLast[2];
  CT_t  mCt[2];
  int   mCnt[2][2];
  int   cntMax[2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkCt(input string name, input CT_t act, input CT_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic CT_t addModel(input CT_t a, input CT_t b);
    CT_t r;
    int  s;
    r = '0;
    for (int k = 0; k < N_SLOTS_L; k++) begin
      s = int'(a.A[k]) + int'(b.A[k]);
      if (s >= int'(Q_MOD)) s -= int'(Q_MOD);
      r.A[k] = s[W_BITS-1:0];
      s = int'(a.B[k]) + int'(b.B[k]);
      if (s >= int'(Q_MOD)) s -= int'(Q_MOD);
      r.B[k] = s[W_BITS-1:0];
    end
    return r;
  endfunction

  function automatic logic [1:0] modelGrant(input logic [1:0] v, input logic last, input bit rr);
    if (v == 2'b11) return (rr && !last) ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic resetModel();
    for (int c = 0; c < 2; c++) begin
      mValid[c]  = 1'b0;
      mId[c]     = 1'b0;
      mLast[c]   = 1'b1;
      mCt[c]     = '0;
      mCnt[c][0] = 0;
      mCnt[c][1] = 0;
    end
    sbQ0.delete();
    sbQ1.delete();
  endtask

  task automatic pulseReset();
    req_valid = 2'b00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic randOps(input int i);
    for (int k = 0; k < N_SLOTS_L; k++) begin
      req_ct1[i].A[k] = W_BITS'($urandom_range(int'(Q_MOD) - 1));
      req_ct1[i].B[k] = W_BITS'($urandom_range(int'(Q_MOD) - 1));
      req_ct2[i].A[k] = W_BITS'($urandom_range(int'(Q_MOD) - 1));
      req_ct2[i].B[k] = W_BITS'($urandom_range(int'(Q_MOD) - 1));
    end
  endtask

  // Drive one cycle, compare both instances with the model, then advance the model.
  task automatic applyStimulus(input logic [1:0] v, input logic rdy);
    logic [1:0]  aRdy[2];
    logic        aVal[2];
    logic        aId[2];
    CT_t         aCt[2];
    logic [31:0] aCnt[2][2];
    logic [1:0]  g, expRdy;
    logic        xid;
    exp_t        e;
    req_valid = v;
    out_ready = rdy;
    #1;
    aRdy[0] = reqReady0;  aRdy[1] = reqReady1;
    aVal[0] = outValid0;  aVal[1] = outValid1;
    aId[0]  = outId0;     aId[1]  = outId1;
    aCt[0]  = outCt0;     aCt[1]  = outCt1;
    aCnt[0][0] = 32'(doneCnt0[0]); aCnt[0][1] = 32'(doneCnt0[1]);
    aCnt[1][0] = 32'(doneCnt1[0]); aCnt[1][1] = 32'(doneCnt1[1]);
    if (reqReady1[1]) fpReady1Seen = 1'b1;
    for (int c = 0; c < 2; c++) begin
      g      = modelGrant(v, mLast[c], c == 0);
      expRdy = g & {2{!mValid[c] || rdy}};
      checkOutput($sformatf("c%0d req_ready", c), 32'(aRdy[c]), 32'(expRdy));
      checkOutput($sformatf("c%0d out_valid", c), 32'(aVal[c]), 32'(mValid[c]));
      if (mValid[c]) begin
        checkOutput($sformatf("c%0d out_id", c), 32'(aId[c]), 32'(mId[c]));
        checkCt($sformatf("c%0d out_ct", c), aCt[c], mCt[c]);
      end
      checkOutput($sformatf("c%0d done_cnt0", c), aCnt[c][0], 32'(mCnt[c][0]));
      checkOutput($sformatf("c%0d done_cnt1", c), aCnt[c][1], 32'(mCnt[c][1]));
      if (aVal[c] && rdy) begin
        if (c == 0) idLog0.push_back(aId[c]);
        else        idLog1.push_back(aId[c]);
        if ((c == 0 && sbQ0.size() == 0) || (c == 1 && sbQ1.size() == 0)) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL c%0d scoreboard: output accepted, expected queue empty", c);
        end else begin
          e = (c == 0) ? sbQ0.pop_front() : sbQ1.pop_front();
          checkOutput($sformatf("c%0d sb id", c), 32'(aId[c]), 32'(e.id));
          checkCt($sformatf("c%0d sb ct", c), aCt[c], e.ct);
        end
      end
      if (mValid[c] && rdy && mCnt[c][mId[c]] < cntMax[c]) mCnt[c][mId[c]]++;
      if (|expRdy) begin
        xid    = expRdy[1];
        e.id   = xid;
        e.ct   = addModel(req_ct1[xid], req_ct2[xid]);
        if (c == 0) sbQ0.push_back(e);
        else        sbQ1.push_back(e);
        mValid[c] = 1'b1;
        mId[c]    = xid;
        mCt[c]    = e.ct;
        mLast[c]  = xid;
      end else if (rdy) begin
        mValid[c] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_rec_t vecs[6];
    logic     expRr[4];
    logic     expFp[4];
    vecs[0] = '{13'd1429, 13'd1081, 13'd5909, 13'd2056, 13'd2510, 13'd255};
    vecs[1] = '{13'd0,    13'd0,    13'd0,    13'd0,    13'd0,    13'd0};
    vecs[2] = '{13'd7709, 13'd1,    13'd3,    13'd4,    13'd0,    13'd7};
    vecs[3] = '{13'd7709, 13'd7709, 13'd3855, 13'd3855, 13'd7708, 13'd0};
    vecs[4] = '{13'd100,  13'd200,  13'd7000, 13'd709,  13'd300,  13'd7709};
    vecs[5] = '{13'd4000, 13'd3710, 13'd1,    13'd2,    13'd0,    13'd3};
    expRr = '{1'b0, 1'b1, 1'b0, 1'b1};
    expFp = '{1'b0, 1'b0, 1'b0, 1'b0};
    cntMax[0] = 65535;
    cntMax[1] = 3;
    fpReady1Seen = 1'b0;
    req_ct1 = '0;
    req_ct2 = '0;

    // Reset state, with requests and out_ready already high
    rst_n     = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst out_valid", 32'({outValid0, outValid1}), 32'd0);
    checkOutput("rst out_id", 32'({outId0, outId1}), 32'd0);
    checkCt("rst out_ct rr", outCt0, '0);
    checkCt("rst out_ct fp", outCt1, '0);
    checkOutput("rst done_cnt rr", 32'(doneCnt0), 32'd0);
    checkOutput("rst done_cnt fp", 32'(doneCnt1), 32'd0);
    checkOutput("rst req_ready", 32'({reqReady0, reqReady1}), 32'd0);
    rst_n = 1'b1;
    resetModel();

    // Table vectors on requester 0, first one in the first cycle out of reset
    for (int i = 0; i < 6; i++) begin
      req_ct1 = '0;
      req_ct2 = '0;
      req_ct1[0].A[0] = vecs[i].a1;
      req_ct2[0].A[0] = vecs[i].a2;
      req_ct1[0].B[4] = vecs[i].b1;
      req_ct2[0].B[4] = vecs[i].b2;
      applyStimulus(2'b01, 1'b1);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(outValid0), 32'd1);
      checkOutput($sformatf("vec%0d out_id", i), 32'(outId0), 32'd0);
      checkOutput($sformatf("vec%0d A0", i), 32'(outCt0.A[0]), 32'(vecs[i].expA));
      checkOutput($sformatf("vec%0d B4", i), 32'(outCt0.B[4]), 32'(vecs[i].expB));
    end
    applyStimulus(2'b00, 1'b1);

    // Both requesters valid for four cycles: alternation vs fixed priority
    pulseReset();
    randOps(0);
    randOps(1);
    idLog0.delete();
    idLog1.delete();
    fpReady1Seen = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b1);
    applyStimulus(2'b00, 1'b1);
    checkOutput("rr id count", 32'(idLog0.size()), 32'd4);
    checkOutput("fp id count", 32'(idLog1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < idLog0.size()) checkOutput($sformatf("rr id seq%0d", i), 32'(idLog0[i]), 32'(expRr[i]));
      if (i < idLog1.size()) checkOutput($sformatf("fp id seq%0d", i), 32'(idLog1[i]), 32'(expFp[i]));
    end
    checkOutput("rr done_cnt0", 32'(doneCnt0[0]), 32'd2);
    checkOutput("rr done_cnt1", 32'(doneCnt0[1]), 32'd2);
    checkOutput("fp done_cnt0 sat", 32'(doneCnt1[0]), 32'd3);
    checkOutput("fp req_ready1 seen", 32'(fpReady1Seen), 32'd0);

    // Back-pressure for three cycles, then back-to-back drain
    pulseReset();
    applyStimulus(2'b11, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 1'b1);
    applyStimulus(2'b00, 1'b1);

    // Asynchronous reset while FULL and stalled
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b01, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 32'({outValid0, outValid1}), 32'd0);
    checkOutput("async rst done_cnt rr", 32'(doneCnt0), 32'd0);
    checkOutput("async rst done_cnt fp", 32'(doneCnt1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();

    // Counter saturation on requester 1
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 1'b1);
    applyStimulus(2'b00, 1'b1);
    checkOutput("sat fp done_cnt1", 32'(doneCnt1[1]), 32'd3);
    checkOutput("sat rr done_cnt1", 32'(doneCnt0[1]), 32'd5);

    // Random out_ready with both requesters busy
    randOps(0);
    randOps(1);
    for (int i = 0; i < 40; i++) applyStimulus(2'b11, 1'($urandom_range(1)));
    applyStimulus(2'b00, 1'b1);
    applyStimulus(2'b00, 1'b1);
    checkOutput("sb rr drained", 32'(sbQ0.size()), 32'd0);
    checkOutput("sb fp drained", 32'(sbQ1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
